rr_grant_sched: RTL

Round-robin scheduler that shares one 3-to-8 select decoder (and the 8 resources it enables) among 8 requesters.
- Owns the decoder's index input and enable, so at most one resource line is active at any time.
- Preemptive hold-time limit: no requester can starve the others.
- Lock input permits atomic multi-cycle transfers.

---
 rtl/rr_grant_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rr_grant_sched.sv
// Round-robin owner of a shared 3-to-8 select decoder: one grant at a time,
// hold-time preemption unless locked, and a mandatory idle cycle between grants.
module rr_grant_sched #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic                     lock,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_en,
  output logic                     timeout,
  output logic [7:0]               hold_cnt
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_en_q, grant_en_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               sel_found_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               owner_req_c;
  logic               hold_expired_c;
  logic [IDX_W-1:0]   ptr_after_owner_c;

  // First pending requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!sel_found_c && req[IDX_W'(ptr_q + IDX_W'(i))]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(ptr_q + IDX_W'(i));
      end
    end
  end

  // >= so that a lock dropped after the limit still preempts on the next edge.
  always_comb begin
    owner_req_c       = req[grant_idx_q];
    hold_expired_c    = !lock && (hold_cnt_q >= HOLD_LIMIT);
    ptr_after_owner_c = IDX_W'(grant_idx_q + IDX_W'(1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;

    case (state_q)
      IDLE: begin
        grant_en_d = 1'b0;
        hold_cnt_d = '0;
        if (sel_found_c) begin
          state_d     = GRANT;
          grant_idx_d = sel_idx_c;
          grant_en_d  = 1'b1;
          hold_cnt_d  = CNT_W'(1);
        end
      end

      GRANT: begin
        if (!owner_req_c) begin
          state_d    = IDLE;
          grant_en_d = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = ptr_after_owner_c;
        end else if (hold_expired_c) begin
          state_d    = IDLE;
          grant_en_d = 1'b0;
          timeout_d  = 1'b1;
          hold_cnt_d = '0;
          ptr_d      = ptr_after_owner_c;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        grant_en_d = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;
  assign timeout   = timeout_q;
  assign hold_cnt  = hold_cnt_q;

endmodule
